matmul_sequencer: RTL

- Command-driven sequencer for the systolic-array controller. It replaces software-timed mode toggling with a single host command.
- It accepts an operation from the PS-side register interface and drives the controller's en/load/write mode lines through LOAD and/or MATMUL phases of fixed length.
- On completion it raises a sticky interrupt. It also reports busy status, abort error and the cycle count of the last command.
- Position in the design: between the AXI/GPIO register block and the array controller, alongside the status-LED logic.

---
 rtl/systolic_pkg.sv | 41 ++++
 rtl/phase_counter.sv | 28 ++
 rtl/matmul_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic-array control path.
package systolic_pkg;

    // Sequencer state; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StMatmul = 2'd2,
        StDone   = 2'd3
    } seq_state_t;

    typedef logic [1:0] cmd_op_t;

    localparam cmd_op_t OP_NOP = 2'b00;
    localparam cmd_op_t OP_RUN = 2'b01;
    localparam cmd_op_t OP_LOAD = 2'b10;
    localparam cmd_op_t OP_MM = 2'b11;

    // Controller mode lines, packed as {load, write}.
    localparam logic [1:0] MODE_READ = 2'b11;
    localparam logic [1:0] MODE_LOAD = 2'b10;
    localparam logic [1:0] MODE_MM = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;

    localparam int unsigned LOAD_CYCLES_DEF = 9;
    localparam int unsigned MM_CYCLES_DEF = 24;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Mode driven to the controller while in a given state.
    function automatic logic [1:0] mode_for(input seq_state_t s);
        unique case (s)
            StLoad:   return MODE_LOAD;
            StMatmul: return MODE_MM;
            default:  return MODE_READ;
        endcase
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that flags the last cycle of a fixed-length phase.
module phase_counter #(
    parameter int unsigned W = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    // Load on phase entry, otherwise count down and rest at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // A count of one means this is the final cycle of the phase.
    assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/matmul_sequencer.sv
// Command-driven sequencer stepping the array controller through LOAD/MATMUL.
module matmul_sequencer
    import systolic_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = LOAD_CYCLES_DEF,
    parameter int unsigned MM_CYCLES   = MM_CYCLES_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             abort,
    input  logic             irq_ack,
    output logic             arr_en,
    output logic             arr_load,
    output logic             arr_write,
    output logic             busy,
    output logic             irq_pending,
    output logic             err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned PhW = $clog2(max_u(LOAD_CYCLES, MM_CYCLES)) + 1;
    localparam logic [PhW-1:0] LoadLen = PhW'(LOAD_CYCLES);
    localparam logic [PhW-1:0] MmLen = PhW'(MM_CYCLES);
    localparam logic [CNT_W-1:0] CntMax = '1;

    seq_state_t       state_q, state_d;
    logic             run_q;
    logic             arr_en_q, arr_load_q, arr_write_q, busy_q;
    logic             irq_q, err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             ph_load;
    logic [PhW-1:0]   ph_val;
    logic             ph_tc;
    logic             in_phase;

    assign in_phase  = (state_q == StLoad) || (state_q == StMatmul);
    assign cmd_ready = (state_q == StIdle) && !irq_q;

    phase_counter #(
        .W (PhW)
    ) u_phase_counter (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .tc_o       (ph_tc)
    );

    // Next state, phase-counter reloads and command acceptance.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ph_load = 1'b0;
        ph_val  = LoadLen;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready && (cmd_op != OP_NOP)) begin
                    accept  = 1'b1;
                    ph_load = 1'b1;
                    if (cmd_op == OP_MM) begin
                        state_d = StMatmul;
                        ph_val  = MmLen;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (ph_tc) begin
                    if (run_q) begin
                        // RUN chains straight into MATMUL with no gap cycle.
                        state_d = StMatmul;
                        ph_load = 1'b1;
                        ph_val  = MmLen;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StMatmul: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (ph_tc) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, registered mode lines, status flags and the busy-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            run_q       <= 1'b0;
            arr_en_q    <= 1'b0;
            arr_load_q  <= 1'b1;
            arr_write_q <= 1'b1;
            busy_q      <= 1'b0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q                   <= state_d;
            {arr_load_q, arr_write_q} <= mode_for(state_d);
            arr_en_q <= (state_d == StLoad) || (state_d == StMatmul);
            busy_q   <= (state_d == StLoad) || (state_d == StMatmul);

            if (accept) begin
                run_q <= (cmd_op == OP_RUN);
                err_q <= 1'b0;
                cnt_q <= '0;
            end else if (in_phase && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (in_phase && abort) begin
                err_q <= 1'b1;
            end

            // Entering DONE beats a simultaneous acknowledge.
            if ((state_d == StDone) && (state_q != StDone)) begin
                irq_q <= 1'b1;
            end else if (irq_ack) begin
                irq_q <= 1'b0;
            end
        end
    end

    // Memory writes stay host-direct; this block must never request them.
    assert property (@(posedge clk) disable iff (!rst)
        {arr_load_q, arr_write_q} != MODE_WRITE);

    assign arr_en      = arr_en_q;
    assign arr_load    = arr_load_q;
    assign arr_write   = arr_write_q;
    assign busy        = busy_q;
    assign irq_pending = irq_q;
    assign err         = err_q;
    assign state_o     = state_q;
    assign cycle_count = cnt_q;

endmodule
